// File: rtl/mips_alu_arbiter.sv
// Two-requester front end sharing one MIPS ALU; at most one operation in flight.
// Define MIPS_ALU_ARB_RR_EN for round-robin contention, otherwise requester 0 always wins.
module mips_alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic [2:0]       alu_control,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             r_id;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   logic w_prio;
   logic w_grant0;
   logic w_grant1;
   logic w_hs;
   logic w_hs_id;
   logic w_rsp_done;

`ifdef MIPS_ALU_ARB_RR_EN
   // Requester that wins the next contention; flips away from whoever was just accepted.
   logic r_prio;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prio <= 1'b0;
      end else if (w_hs) begin
         r_prio <= ~w_hs_id;
      end
   end

   assign w_prio = r_prio;
`else
   assign w_prio = 1'b0;
`endif

   assign w_grant0   = req0_valid & (~req1_valid | ~w_prio);
   assign w_grant1   = req1_valid & (~req0_valid |  w_prio);
   assign w_hs       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign w_hs_id    = req1_ready;
   assign w_rsp_done = (r_state == S_RESP) & (r_id ? rsp1_ready : rsp0_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_state_next = S_EXEC;
         S_EXEC:  w_state_next = S_RESP;
         S_RESP:  if (w_rsp_done) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            req0_ready = w_grant0;
            req1_ready = w_grant1;
         end
         S_RESP: begin
            rsp0_valid = ~r_id;
            rsp1_valid =  r_id;
         end
         default: ;
      endcase
   end

   // Operand latch on handshake; result captured only while the ALU is driven from the latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_id     <= 1'b0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         if (w_hs) begin
            r_id <= w_hs_id;
            r_op <= w_hs_id ? req1_op : req0_op;
            r_a  <= w_hs_id ? req1_a  : req0_a;
            r_b  <= w_hs_id ? req1_b  : req0_b;
         end
         if (r_state == S_EXEC) begin
            r_result <= alu_out;
            r_zero   <= alu_zero;
         end
      end
   end

   assign alu_control = r_op;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign rsp_result  = r_result;
   assign rsp_zero    = r_zero;

endmodule

// File: tb/tb_mips_alu_arbiter.sv
// Self-checking bench for mips_alu_arbiter with a behavioural ALU stub and transaction-level model.
module tb_mips_alu_arbiter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [2:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready, rsp1_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_zero;
   logic [2:0]   alu_control;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic         alu_zero;

   int n_cmp = 0;
   int n_bad = 0;
   int mdl_last = 1;   // requester accepted last; 1 means requester 0 has priority next

   always #5 clk = ~clk;

   mips_alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero)
   );

   function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd6:    return a - b;
         3'd7:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: return '0;
      endcase
   endfunction

   assign alu_out  = ref_alu(alu_control, alu_a, alu_b);
   assign alu_zero = (alu_out == '0);

   // Expected grant: -1 none, otherwise requester index.
   function automatic int exp_grant(input bit v0, input bit v1);
      if (!v0 && !v1) return -1;
      if (v0 && !v1) return 0;
      if (v1 && !v0) return 1;
`ifdef MIPS_ALU_ARB_RR_EN
      return (mdl_last == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic drive_req(input int n, input bit v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (n == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic clear_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
      mdl_last = 1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); end
      n_cmp++; if (rsp_result !== '0 || rsp_zero !== 1'b0) begin n_bad++; $display("FAIL reset_result: got %0h/%b expected 0/0", rsp_result, rsp_zero); end
      n_cmp++; if (alu_control !== 3'd0 || alu_a !== '0 || alu_b !== '0) begin n_bad++; $display("FAIL reset_alu: got %0d/%0h/%0h expected 0/0/0", alu_control, alu_a, alu_b); end
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready_idle: got %b expected 00", {req0_ready, req1_ready}); end
      $display("test_reset: done");
   endtask

   task automatic test_single();
      drive_req(0, 1'b1, 3'd2, 32'd5, 32'd7);
      #1;
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready); end
      @(posedge clk); mdl_last = 0;
      @(negedge clk);
      req0_valid = 1'b0;
      n_cmp++; if (alu_control !== 3'd2 || rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL single_exec: got ctl=%0d rsp0_valid=%b expected ctl=2 rsp0_valid=0", alu_control, rsp0_valid); end
      @(negedge clk);
      n_cmp++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL single_latency: got %b%b expected 10", rsp0_valid, rsp1_valid); end
      n_cmp++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin n_bad++; $display("FAIL single_result: got %0d/%b expected 12/0", rsp_result, rsp_zero); end
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      n_cmp++; if (rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL single_release: got %b expected 0", rsp0_valid); end
      $display("test_single: op=2 a=5 b=7 result=%0d", rsp_result);
   endtask

   task automatic test_sub_zero();
      drive_req(1, 1'b1, 3'd6, 32'd9, 32'd9);
      #1;
      n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL subz_ready: got %b expected 1", req1_ready); end
      @(posedge clk); mdl_last = 1;
      @(negedge clk);
      req1_valid = 1'b0;
      rsp1_ready = 1'b1;   // outside RESP: must be ignored
      @(negedge clk);
      rsp1_ready = 1'b0;
      rsp0_ready = 1'b1;   // non-owner: must be ignored
      n_cmp++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL subz_valid: got rsp1=%b rsp0=%b expected 1/0", rsp1_valid, rsp0_valid); end
      n_cmp++; if (rsp_result !== '0 || rsp_zero !== 1'b1) begin n_bad++; $display("FAIL subz_result: got %0d/%b expected 0/1", rsp_result, rsp_zero); end
      @(negedge clk);
      rsp0_ready = 1'b0;
      n_cmp++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL subz_nonowner_ready: got rsp1=%b rsp0=%b expected 1/0", rsp1_valid, rsp0_valid); end
      rsp1_ready = 1'b1;
      @(negedge clk);
      rsp1_ready = 1'b0;
      n_cmp++; if (rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL subz_release: got %b expected 0", rsp1_valid); end
      $display("test_sub_zero: op=6 a=9 b=9 zero=%b", rsp_zero);
   endtask

   task automatic test_contention();
      int g;
      logic [W-1:0] exp;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_req(0, 1'b1, 3'd2, 32'd1, 32'd1);
         drive_req(1, 1'b1, 3'd1, 32'd4, 32'd1);
         #1;
         g = exp_grant(1'b1, 1'b1);
`ifdef MIPS_ALU_ARB_RR_EN
         n_cmp++; if (g != (i % 2)) begin n_bad++; $display("FAIL cont_model_seq: got %0d expected %0d", g, i % 2); end
`endif
         exp = (g == 0) ? 32'd2 : 32'd5;
         n_cmp++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin n_bad++; $display("FAIL cont_grant[%0d]: got %b%b expected grant %0d", i, req0_ready, req1_ready, g); end
         @(posedge clk); mdl_last = g;
         @(negedge clk);
         n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL cont_exec_ready[%0d]: got %b%b expected 00", i, req0_ready, req1_ready); end
         @(negedge clk);
         n_cmp++; if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1) || rsp_result !== exp) begin n_bad++; $display("FAIL cont_rsp[%0d]: got v=%b%b res=%0d expected grant %0d res=%0d", i, rsp0_valid, rsp1_valid, rsp_result, g, exp); end
         if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
         @(negedge clk);
         rsp0_ready = 1'b0; rsp1_ready = 1'b0;
         $display("test_contention: txn %0d granted req%0d result=%0d", i, g, exp);
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      int g;
      drive_req(0, 1'b1, 3'd7, 32'd3, 32'd8);
      #1;
      n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready: got %b expected 1", req0_ready); end
      @(posedge clk); mdl_last = 0;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd1) begin n_bad++; $display("FAIL bp_first: got v=%b res=%0d expected 1/1", rsp0_valid, rsp_result); end
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         #1;
         n_cmp++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd1 || {req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b res=%0d rdy=%b%b expected 1/1/00", i, rsp0_valid, rsp_result, req0_ready, req1_ready); end
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_consume_ready: got %b%b expected 00", req0_ready, req1_ready); end
      @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      g = exp_grant(1'b1, 1'b1);
      n_cmp++; if (rsp0_valid !== 1'b0 || req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin n_bad++; $display("FAIL bp_idle: got v=%b rdy=%b%b expected v=0 grant %0d", rsp0_valid, req0_ready, req1_ready, g); end
      clear_inputs();   // withdraw before the edge: grant lost, nothing accepted
      @(negedge clk);
      $display("test_backpressure: slt 3<8 held result=%0d", rsp_result);
   endtask

   task automatic test_reset_exec();
      drive_req(0, 1'b1, 3'd2, 32'd1, 32'd1);
      @(posedge clk); mdl_last = 0;
      @(negedge clk);
      req0_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mdl_last = 1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp_result !== '0 || alu_control !== 3'd0) begin n_bad++; $display("FAIL rexec_abort[%0d]: got v=%b%b res=%0d ctl=%0d expected 00/0/0", i, rsp0_valid, rsp1_valid, rsp_result, alu_control); end
         @(negedge clk);
      end
      // reset coinciding with a handshake wins
      drive_req(0, 1'b1, 3'd2, 32'd6, 32'd6);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req0_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || alu_control !== 3'd0 || alu_a !== '0) begin n_bad++; $display("FAIL rsim_abort[%0d]: got v=%b%b ctl=%0d a=%0h expected 00/0/0", i, rsp0_valid, rsp1_valid, alu_control, alu_a); end
         @(negedge clk);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_bad++; $display("FAIL rexec_prio: got %b%b expected 10", req0_ready, req1_ready); end
      clear_inputs();
      @(negedge clk);
      drive_req(1, 1'b1, 3'd2, 32'd2, 32'd3);
      #1;
      n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL rexec_next_ready: got %b expected 1", req1_ready); end
      @(posedge clk); mdl_last = 1;
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'd5) begin n_bad++; $display("FAIL rexec_next: got v=%b res=%0d expected 1/5", rsp1_valid, rsp_result); end
      rsp1_ready = 1'b1;
      @(negedge clk);
      rsp1_ready = 1'b0;
      $display("test_reset_exec: post-reset result=%0d", rsp_result);
   endtask

   task automatic test_random();
      bit v0, v1;
      int g, hold;
      logic [2:0] op0, op1, op;
      logic [W-1:0] a0, b0, a1, b1, exp_r;
      for (int t = 0; t < 40; t++) begin
         do begin v0 = 1'($urandom); v1 = 1'($urandom); end while (!v0 && !v1);
         op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
         a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
         drive_req(0, v0, op0, a0, b0);
         drive_req(1, v1, op1, a1, b1);
         #1;
         g = exp_grant(v0, v1);
         n_cmp++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin n_bad++; $display("FAIL rnd_grant[%0d]: got %b%b expected grant %0d", t, req0_ready, req1_ready, g); end
         op = (g == 0) ? op0 : op1;
         exp_r = (g == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
         hold = $urandom_range(0, 3);
         @(posedge clk); mdl_last = g;
         @(negedge clk);
         req0_valid = 1'($urandom); req1_valid = 1'($urandom);
         rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
         #1;
         n_cmp++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000 || alu_control !== op) begin n_bad++; $display("FAIL rnd_exec[%0d]: got rdy=%b%b v=%b%b ctl=%0d expected 0000 ctl=%0d", t, req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_control, op); end
         @(negedge clk);
         for (int h = 0; h <= hold; h++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            if (g == 0) begin rsp0_ready = (h == hold); rsp1_ready = 1'($urandom); end
            else        begin rsp1_ready = (h == hold); rsp0_ready = 1'($urandom); end
            #1;
            n_cmp++; if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1) || rsp_result !== exp_r || rsp_zero !== (exp_r == '0) || {req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rnd_rsp[%0d.%0d]: got v=%b%b res=%0h z=%b rdy=%b%b expected owner %0d res=%0h z=%b", t, h, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, req0_ready, req1_ready, g, exp_r, exp_r == '0); end
            @(negedge clk);
         end
         clear_inputs();
         n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_bad++; $display("FAIL rnd_release[%0d]: got %b%b expected 00", t, rsp0_valid, rsp1_valid); end
         $display("test_random: txn %0d req%0d op=%0d result=%0h hold=%0d", t, g, op, exp_r, hold);
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      drive_req(0, 1'b0, 3'd0, '0, '0);
      drive_req(1, 1'b0, 3'd0, '0, '0);
      test_reset();
      test_single();
      test_sub_zero();
      test_contention();
      test_backpressure();
      test_reset_exec();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
